// File: rtl/sdram_ring_seq_if.sv
// Stream-side and SDRAM-access-side signal bundle for sdram_ring_seq.
// master: the sequencer's view; slave: the environment (producer, consumer, access stage).
interface sdram_ring_seq_if #(
    parameter int unsigned ADDR_W = 25
);
    // input sample stream
    logic              in_valid;
    logic [31:0]       in_data;
    logic              in_ready;

    // read-back side
    logic              out_req;
    logic              out_busy;
    logic              out_valid;
    logic [31:0]       out_data;
    logic [ADDR_W:0]   level;

    // single-word SDRAM access stage
    logic              sd_wr;
    logic              sd_rd;
    logic [ADDR_W-1:0] sd_addr_wr;
    logic [ADDR_W-1:0] sd_addr_rd;
    logic [31:0]       sd_data_wr;
    logic              sd_ok;
    logic [31:0]       sd_data_rd;
    logic              sd_en;

    modport master (
        input  in_valid, in_data,
        output in_ready,
        input  out_req,
        output out_busy, out_valid, out_data, level,
        output sd_wr, sd_rd, sd_addr_wr, sd_addr_rd, sd_data_wr,
        input  sd_ok, sd_data_rd, sd_en
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready,
        output out_req,
        input  out_busy, out_valid, out_data, level,
        input  sd_wr, sd_rd, sd_addr_wr, sd_addr_rd, sd_data_wr,
        output sd_ok, sd_data_rd, sd_en
    );
endinterface

// File: rtl/sdram_ring_seq.sv
// Ring-buffer sequencer in front of a single-word SDRAM access stage.
// Buffers an input word stream in a small FIFO, writes it into an SDRAM
// ring and serves single-word FIFO-order reads, one SDRAM operation at a time.
module sdram_ring_seq #(
    parameter int unsigned ADDR_W     = 25,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int unsigned RING_WORDS = 1024,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    sdram_ring_seq_if.master bus
);
    localparam int unsigned       FIFO_AW   = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(RING_WORDS - 1);
    localparam logic [ADDR_W:0]   LVL_FULL  = (ADDR_W + 1)'(RING_WORDS);
    localparam logic [FIFO_AW:0]  FIFO_FULL = (FIFO_AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GUARD,
        S_WAIT
    } state_t;

    state_t            state;
    state_t            state_nx;

    // input FIFO
    logic [31:0]       fifo_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] fifo_wp;
    logic [FIFO_AW-1:0] fifo_rp;
    logic [FIFO_AW:0]  fifo_cnt;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;

    // ring bookkeeping
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   level_r;

    // operation tracking
    logic              op_active;
    logic              op_is_wr;
    logic              prefer_rd;
    logic              rd_inflight;
    logic              wr_elig;
    logic              rd_elig;
    logic              issue_wr;
    logic              issue_rd;
    logic              op_done;
    logic              rd_capture;

    // registered outputs
    logic              out_busy_r;
    logic              out_valid_r;
    logic [31:0]       out_data_r;
    logic [ADDR_W-1:0] addr_wr_r;
    logic [ADDR_W-1:0] addr_rd_r;
    logic [31:0]       data_wr_r;

    assign fifo_full  = (fifo_cnt == FIFO_FULL);
    assign fifo_empty = (fifo_cnt == '0);
    assign push       = bus.in_valid && !fifo_full;
    assign pop        = issue_wr;

    assign wr_elig    = !fifo_empty && (level_r < LVL_FULL);
    assign rd_elig    = out_busy_r && !rd_inflight && (level_r != '0);

    // op_active stays low after reset so the first WAIT exit (the access
    // stage may still be finishing an abandoned operation) moves no pointer
    assign op_done    = (state == S_WAIT) && bus.sd_ok && op_active;
    assign rd_capture = bus.sd_en && op_active && !op_is_wr && rd_inflight &&
                        (state != S_IDLE);

    // State register; reset parks in WAIT until the access stage reports idle
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_WAIT;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and issue decision; write/read alternate when both are eligible
    always_comb begin
        state_nx = state;
        issue_wr = 1'b0;
        issue_rd = 1'b0;
        case (state)
            S_IDLE: begin
                if (wr_elig && (!rd_elig || !prefer_rd)) begin
                    issue_wr = 1'b1;
                    state_nx = S_GUARD;
                end else if (rd_elig) begin
                    issue_rd = 1'b1;
                    state_nx = S_GUARD;
                end
            end
            S_GUARD: begin
                state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (bus.sd_ok) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_WAIT;
            end
        endcase
    end

    // Output drive: start pulses come straight from the IDLE issue decision
    always_comb begin
        bus.sd_wr      = issue_wr;
        bus.sd_rd      = issue_rd;
        bus.sd_addr_wr = addr_wr_r;
        bus.sd_addr_rd = addr_rd_r;
        bus.sd_data_wr = data_wr_r;
        bus.in_ready   = !fifo_full;
        bus.out_busy   = out_busy_r;
        bus.out_valid  = out_valid_r;
        bus.out_data   = out_data_r;
        bus.level      = level_r;
    end

    // FIFO storage; contents need no reset
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[fifo_wp] <= bus.in_data;
        end
    end

    // FIFO pointers and occupancy; push and pop may coincide
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_wp  <= '0;
            fifo_rp  <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                fifo_wp <= fifo_wp + FIFO_AW'(1);
            end
            if (pop) begin
                fifo_rp <= fifo_rp + FIFO_AW'(1);
            end
            fifo_cnt <= fifo_cnt + {{FIFO_AW{1'b0}}, push} - {{FIFO_AW{1'b0}}, pop};
        end
    end

    // Issue registers and ring pointers; pointers and level move on WAIT exit
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_wr_r <= '0;
            addr_rd_r <= '0;
            data_wr_r <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level_r   <= '0;
            op_active <= 1'b0;
            op_is_wr  <= 1'b0;
            prefer_rd <= 1'b0;
        end else begin
            if (issue_wr) begin
                addr_wr_r <= BASE + wr_ptr;
                data_wr_r <= fifo_mem[fifo_rp];
            end
            if (issue_rd) begin
                addr_rd_r <= BASE + rd_ptr;
            end
            if (issue_wr || issue_rd) begin
                op_active <= 1'b1;
                op_is_wr  <= issue_wr;
                prefer_rd <= issue_wr;
            end
            if (op_done) begin
                op_active <= 1'b0;
                if (op_is_wr) begin
                    wr_ptr  <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + ADDR_W'(1);
                    level_r <= level_r + (ADDR_W + 1)'(1);
                end else begin
                    rd_ptr  <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + ADDR_W'(1);
                    level_r <= level_r - (ADDR_W + 1)'(1);
                end
            end
        end
    end

    // Read request tracking and data return
    always_ff @(posedge clk) begin
        if (rst) begin
            out_busy_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            rd_inflight <= 1'b0;
        end else begin
            out_valid_r <= rd_capture;
            if (rd_capture) begin
                out_data_r  <= bus.sd_data_rd;
                out_busy_r  <= 1'b0;
                rd_inflight <= 1'b0;
            end else begin
                if (bus.out_req && !out_busy_r) begin
                    out_busy_r <= 1'b1;
                end
                if (issue_rd) begin
                    rd_inflight <= 1'b1;
                end
            end
        end
    end
endmodule
